log_capture_ctrl: RTL and testbench

Parametrised, triggered capture logger for filter-output samples, with a single inferred circular BRAM of depth 2^BRAM_ADDR_WIDTH.
- Once armed, writes accepted samples continuously (pre-trigger history).
- On trigger, writes a programmable number of post-trigger samples, then freezes.
- The captured window is read back chronologically; readout address 0 is always the oldest sample.
- Sits between the filter outputs and the host/debug readout path.

---
 rtl/log_capture_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_log_capture_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_capture_ctrl.sv
// log_capture_ctrl: triggered capture logger for filter-output samples into one circular BRAM.
// Latency: each accepted sample is written on the clock edge that accepts it; read data appears one cycle after i_read_log.
// Backpressure: none. Samples are taken whenever i_valid is high in ARM/POST, and reads are served at full rate in DONE.
//
// Ports:
//   clk, i_rst                       clock and synchronous active-high reset
//   i_filter_data, i_valid           sample stream (I upper half, Q lower half)
//   i_run_log, i_trigger             arm request and trigger event
//   i_post_len, i_decim              post-trigger count and decimation factor, both latched at arm
//   i_read_log, i_addr_log_to_mem    read request and logical index (0 = oldest sample)
//   o_mem_full, o_busy, o_wrapped    status flags
//   o_trig_addr                      logical index of the first post-trigger sample
//   o_data_log_from_mem, o_rd_valid  read data, one cycle after the request
//
// Build option: define LOG_DECIM_EN to build the decimator. Without it, i_decim is ignored
// and every valid sample is accepted.

module log_capture_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int DECIM_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [BRAM_DATA_WIDTH-1:0] i_filter_data,
    input  logic                       i_valid,
    input  logic                       i_run_log,
    input  logic                       i_trigger,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_post_len,
    input  logic [DECIM_WIDTH-1:0]     i_decim,
    input  logic                       i_read_log,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_addr_log_to_mem,
    output logic                       o_mem_full,
    output logic                       o_busy,
    output logic                       o_wrapped,
    output logic [BRAM_ADDR_WIDTH-1:0] o_trig_addr,
    output logic [BRAM_DATA_WIDTH-1:0] o_data_log_from_mem,
    output logic                       o_rd_valid
);

    localparam int DEPTH = 2 ** BRAM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_POST,
        S_DONE
    } state_t;

    state_t                       state;
    logic [BRAM_ADDR_WIDTH-1:0]   wr_ptr;
    logic [BRAM_ADDR_WIDTH-1:0]   post_cnt;
    logic [BRAM_ADDR_WIDTH-1:0]   post_len_q;
    logic [BRAM_ADDR_WIDTH-1:0]   trig_ptr;

    logic [BRAM_DATA_WIDTH-1:0]   mem [DEPTH];

    logic                         capturing;
    logic                         arm_edge;
    logic                         accept;
    logic                         wr_en;
    logic [BRAM_ADDR_WIDTH-1:0]   wr_ptr_nxt;
    logic                         wrapped_nxt;
    logic [BRAM_ADDR_WIDTH-1:0]   start_nxt;
    logic [BRAM_ADDR_WIDTH-1:0]   post_cnt_inc;
    logic [BRAM_ADDR_WIDTH-1:0]   rd_phys;

    assign capturing = (state == S_ARM) || (state == S_POST);
    assign arm_edge  = ((state == S_IDLE) || (state == S_DONE)) && i_run_log;

`ifdef LOG_DECIM_EN
    logic [DECIM_WIDTH-1:0] decim_q;
    logic [DECIM_WIDTH-1:0] decim_cnt;

    assign accept = capturing && i_valid && (decim_cnt == '0);

    // Counts every valid sample while capturing; only phase 0 of each
    // (decim_q+1)-long group is stored.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            decim_q   <= '0;
            decim_cnt <= '0;
        end else if (arm_edge) begin
            decim_q   <= i_decim;
            decim_cnt <= '0;
        end else if (capturing && i_valid) begin
            if (decim_cnt == decim_q) begin
                decim_cnt <= '0;
            end else begin
                decim_cnt <= decim_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_decim;

    assign accept       = capturing && i_valid;
    assign unused_decim = ^i_decim;
`endif

    // A reset in the same cycle as a sample aborts that write as well.
    assign wr_en        = accept && !i_rst;
    assign wr_ptr_nxt   = wr_en ? wr_ptr + 1'b1 : wr_ptr;
    assign wrapped_nxt  = o_wrapped || (wr_en && (wr_ptr == '1));
    // Oldest surviving sample once capture ends: after a wrap it sits at the
    // next write slot, otherwise at physical address 0.
    assign start_nxt    = wrapped_nxt ? wr_ptr_nxt : '0;
    assign post_cnt_inc = post_cnt + 1'b1;

    // Sample memory: write port only, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_filter_data;
        end
    end

    // Window start is stable in DONE, so logical->physical is a plain add
    // that wraps naturally at the address width.
    assign rd_phys = (o_wrapped ? wr_ptr : '0) + i_addr_log_to_mem;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_rd_valid          <= 1'b0;
            o_data_log_from_mem <= '0;
        end else if ((state == S_DONE) && i_read_log) begin
            o_rd_valid          <= 1'b1;
            o_data_log_from_mem <= mem[rd_phys];
        end else begin
            o_rd_valid          <= 1'b0;
            o_data_log_from_mem <= '0;
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            post_cnt    <= '0;
            post_len_q  <= '0;
            trig_ptr    <= '0;
            o_wrapped   <= 1'b0;
            o_trig_addr <= '0;
            o_mem_full  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr_nxt;
                if (wr_ptr == '1) begin
                    o_wrapped <= 1'b1;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (i_run_log) begin
                        state       <= S_ARM;
                        wr_ptr      <= '0;
                        post_cnt    <= '0;
                        post_len_q  <= i_post_len;
                        trig_ptr    <= '0;
                        o_wrapped   <= 1'b0;
                        o_trig_addr <= '0;
                        o_mem_full  <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end

                S_ARM: begin
                    if (i_trigger) begin
                        // A sample stored in the trigger cycle is still
                        // history, so the trigger points past it.
                        trig_ptr <= wr_ptr_nxt;
                        post_cnt <= '0;
                        if (post_len_q == '0) begin
                            state       <= S_DONE;
                            o_busy      <= 1'b0;
                            o_mem_full  <= 1'b1;
                            o_trig_addr <= wr_ptr_nxt - start_nxt;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end

                S_POST: begin
                    if (wr_en) begin
                        post_cnt <= post_cnt_inc;
                        if (post_cnt_inc == post_len_q) begin
                            state       <= S_DONE;
                            o_busy      <= 1'b0;
                            o_mem_full  <= 1'b1;
                            o_trig_addr <= trig_ptr - start_nxt;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_capture_ctrl.sv
// tb_log_capture_ctrl: directed and randomized capture scenarios checked against a sample-queue model.
// Latency: checks are made 1 ns after each rising edge; read data is expected one cycle after the request.
// Backpressure: none; the DUT takes stimulus every cycle.

module tb_log_capture_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int XW = 8;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [DW-1:0] i_filter_data;
    logic          i_valid;
    logic          i_run_log;
    logic          i_trigger;
    logic [AW-1:0] i_post_len;
    logic [XW-1:0] i_decim;
    logic          i_read_log;
    logic [AW-1:0] i_addr_log_to_mem;
    logic          o_mem_full;
    logic          o_busy;
    logic          o_wrapped;
    logic [AW-1:0] o_trig_addr;
    logic [DW-1:0] o_data_log_from_mem;
    logic          o_rd_valid;

    always #5 clk = ~clk;

    log_capture_ctrl #(
        .BRAM_ADDR_WIDTH(AW),
        .BRAM_DATA_WIDTH(DW),
        .DECIM_WIDTH    (XW)
    ) dut (
        .clk                (clk),
        .i_rst              (i_rst),
        .i_filter_data      (i_filter_data),
        .i_valid            (i_valid),
        .i_run_log          (i_run_log),
        .i_trigger          (i_trigger),
        .i_post_len         (i_post_len),
        .i_decim            (i_decim),
        .i_read_log         (i_read_log),
        .i_addr_log_to_mem  (i_addr_log_to_mem),
        .o_mem_full         (o_mem_full),
        .o_busy             (o_busy),
        .o_wrapped          (o_wrapped),
        .o_trig_addr        (o_trig_addr),
        .o_data_log_from_mem(o_data_log_from_mem),
        .o_rd_valid         (o_rd_valid)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the ordered list of samples stored since arm; the
    // window is simply the last D entries of that list.
    typedef enum {M_IDLE, M_ARM, M_POST, M_DONE} mstate_t;
    mstate_t       ms = M_IDLE;
    logic [DW-1:0] samples[$];
    int            valid_cnt  = 0;
    int            trig_cnt   = 0;
    int            m_post_len = 0;
    int            m_decim    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_trig();
        int n;
        int v;
        n = samples.size();
        if (ms != M_DONE) return '0;
        v = (n >= D) ? trig_cnt - n : trig_cnt;
        v = ((v % D) + D) % D;
        return v[AW-1:0];
    endfunction

    task automatic model_arm();
        samples.delete();
        valid_cnt  = 0;
        trig_cnt   = 0;
        m_post_len = int'(i_post_len);
`ifdef LOG_DECIM_EN
        m_decim    = int'(i_decim);
`else
        m_decim    = 0;
`endif
        ms         = M_ARM;
    endtask

    task automatic check_status();
        chk("busy",     32'(o_busy),      32'((ms == M_ARM) || (ms == M_POST)));
        chk("mem_full", 32'(o_mem_full),  32'(ms == M_DONE));
        chk("wrapped",  32'(o_wrapped),   32'(samples.size() >= D));
        chk("trig_addr", 32'(o_trig_addr), 32'(exp_trig()));
    endtask

    // One clock of stimulus, model update, and output checks.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic run,
                        input logic trg, input logic rd, input int idx);
        mstate_t       pre;
        int            n;
        logic          exp_rv;
        logic [DW-1:0] exp_rd;
        logic          rd_known;
        i_valid           = v;
        i_filter_data     = d;
        i_run_log         = run;
        i_trigger         = trg;
        i_read_log        = rd;
        i_addr_log_to_mem = idx[AW-1:0];
        pre      = ms;
        exp_rv   = rd && (pre == M_DONE);
        exp_rd   = '0;
        rd_known = 1'b1;
        if (exp_rv) begin
            n = samples.size();
            if (n >= D)       exp_rd = samples[n - D + idx];
            else if (idx < n) exp_rd = samples[idx];
            else              rd_known = 1'b0;  // beyond written data: stale RAM
        end
        @(posedge clk);
        if ((pre == M_ARM) || (pre == M_POST)) begin
            if (v) begin
                if ((valid_cnt % (m_decim + 1)) == 0) samples.push_back(d);
                valid_cnt++;
            end
        end
        case (pre)
            M_IDLE, M_DONE: if (run) model_arm();
            M_ARM: if (trg) begin
                trig_cnt = samples.size();
                ms = (m_post_len == 0) ? M_DONE : M_POST;
            end
            M_POST: if (samples.size() - trig_cnt == m_post_len) ms = M_DONE;
            default: ;
        endcase
        #1;
        check_status();
        chk("rd_valid", 32'(o_rd_valid), 32'(exp_rv));
        if (rd_known) chk("rd_data", 32'(o_data_log_from_mem), 32'(exp_rd));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge clk);
        ms = M_IDLE;
        samples.delete();
        valid_cnt = 0;
        trig_cnt  = 0;
        #1;
        chk("rst_mem_full",  32'(o_mem_full),          32'(0));
        chk("rst_busy",      32'(o_busy),              32'(0));
        chk("rst_wrapped",   32'(o_wrapped),           32'(0));
        chk("rst_trig_addr", 32'(o_trig_addr),         32'(0));
        chk("rst_rd_valid",  32'(o_rd_valid),          32'(0));
        chk("rst_rd_data",   32'(o_data_log_from_mem), 32'(0));
        i_rst = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < D; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, i);
    endtask

    // Random-density capture: trigger after pre_cycles, run until DONE or budget.
    task automatic run_capture(input int pre_cycles, input int pct, input int budget);
        int c;
        c = 0;
        while ((ms != M_DONE) && (c < budget)) begin
            i_decim    = XW'($urandom());
            i_post_len = AW'($urandom());
            step(($urandom_range(99) < pct), DW'($urandom()), 1'b0, (c == pre_cycles), 1'b0, 0);
            c++;
        end
        chk("capture_done", 32'(o_mem_full), 32'(1));
    endtask

    initial begin
        i_rst = 1'b1;
        i_filter_data = '0; i_valid = 1'b0; i_run_log = 1'b0; i_trigger = 1'b0;
        i_post_len = '0; i_decim = '0; i_read_log = 1'b0; i_addr_log_to_mem = '0;

        do_reset();
        step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 0);  // idle: trigger/read/valid ignored

        // 1: short capture without wrap
        i_post_len = 4; i_decim = 0;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 10; k++) step(1'b1, DW'(k), 1'b0, (k == 5), 1'b0, 0);
        chk("t1_mem_full", 32'(o_mem_full), 32'(1));
        chk("t1_trig", 32'(o_trig_addr), 32'(6));
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, i);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 0);

        // 2: wrapped capture, 40 pre-trigger samples then 3 post
        i_post_len = 3;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 43; k++) step(1'b1, DW'(k), 1'b0, (k == 39), 1'b0, 0);
        chk("t2_wrapped", 32'(o_wrapped), 32'(1));
        chk("t2_trig", 32'(o_trig_addr), 32'(13));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 0);
        chk("t2_idx0", 32'(o_data_log_from_mem), 32'h1B);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 15);
        chk("t2_idx15", 32'(o_data_log_from_mem), 32'h2A);
        read_all();

        // 3: post_len = 0, trigger alongside a sample
        i_post_len = 0;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 5; k++) step(1'b1, DW'(16'h100 + k), 1'b0, (k == 4), 1'b0, 0);
        chk("t3_done", 32'(o_mem_full), 32'(1));
        chk("t3_trig", 32'(o_trig_addr), 32'(5));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4);
        chk("t3_last", 32'(o_data_log_from_mem), 32'h104);

        // 4: decimation by 3 (or every sample when the decimator is not built)
        i_post_len = 3; i_decim = 2;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; (k < 40) && (ms != M_DONE); k++) step(1'b1, DW'(k), 1'b0, (k == 0), 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, i);
`ifdef LOG_DECIM_EN
            chk("t4_decim", 32'(o_data_log_from_mem), 32'(3 * i));
`else
            chk("t4_nodecim", 32'(o_data_log_from_mem), 32'(i));
`endif
        end

        // 5: reset mid-POST aborts; reads in IDLE stay invalid; re-arm works
        i_post_len = 10; i_decim = 0;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 8; k++) step(1'b1, DW'(16'h200 + k), 1'b0, (k == 5), 1'b0, 0);
        chk("t5_in_post", 32'(o_busy), 32'(1));
        i_read_log = 1'b1;
        do_reset();
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 0);
        chk("t5_no_rd", 32'(o_rd_valid), 32'(0));
        i_post_len = 7;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        run_capture(25, 70, 400);
        read_all();

        // 6: DONE ignores trigger and samples; re-arm clears mem_full
        for (int k = 0; k < 6; k++) step(k[0], DW'(16'hDEAD), 1'b0, ~k[0], 1'b0, 0);
        read_all();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        chk("t6_rearm_full", 32'(o_mem_full), 32'(0));
        chk("t6_rearm_busy", 32'(o_busy), 32'(1));

        // Randomized rounds (already armed for the first)
        for (int r = 0; r < 6; r++) begin
            if (r != 0) begin
                i_post_len = AW'($urandom());
                i_decim    = XW'($urandom_range(3));
                step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
            end
            run_capture($urandom_range(45), $urandom_range(40, 100), 600);
            for (int j = 0; j < 20; j++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom_range(D - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
